// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// arbiter state encoding and the latched memory request record.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address;
    logic [31:0] wdata;
  } mem_req_t;

  localparam mem_req_t REQ_NONE = '0;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch side (read-only) and the
// load/store side; one transfer at a time, memory port driven only from registers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RR_MODE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam logic RR_EN = (RR_MODE != 0);

  arb_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_d_q, last_d_d;
  logic        d_req;
  logic        grant_d;

  assign d_req = d_read | d_write;
  // On conflict D wins unless round-robin is enabled and D had the last turn.
  assign grant_d = d_req & (~i_read | ~RR_EN | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          req_d.read    = d_read;
          req_d.write   = d_write;
          req_d.wmask   = d_wmask;
          req_d.address = d_address;
          req_d.wdata   = d_wdata;
          state_d       = BUSY_D;
        end else if (i_read) begin
          req_d         = REQ_NONE;
          req_d.read    = 1'b1;
          req_d.address = i_address;
          state_d       = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          rdata_d     = mem_rdata;
          last_d_d    = (state_q == BUSY_D);
          // Clearing the strobes here makes the port idle during DONE.
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          state_d     = (state_q == BUSY_D) ? DONE_D : DONE_I;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= REQ_NONE;
      rdata_q  <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      last_d_q <= last_d_d;
    end
  end

  assign mem_read    = req_q.read;
  assign mem_write   = req_q.write;
  assign mem_wmask   = req_q.wmask;
  assign mem_address = req_q.address;
  assign mem_wdata   = req_q.wdata;

  assign i_resp  = (state_q == DONE_I);
  assign d_resp  = (state_q == DONE_D);
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance on a behavioural
// memory with programmable wait states, plus a fixed-priority instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = '0;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [3:0]  d_wmask = '0;
  logic [31:0] d_address = '0, d_wdata = '0;

  logic        i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        i_resp_p, d_resp_p, mem_read_p, mem_write_p, mem_resp_p;
  logic [31:0] i_rdata_p, d_rdata_p, mem_address_p, mem_wdata_p;
  logic [3:0]  mem_wmask_p;

  logic [31:0] tb_mem [256];
  logic [7:0]  wcnt = '0;
  logic [7:0]  wait_cfg = '0;
  logic        hold_off = 1'b0;
  logic        force_resp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.RR_MODE(0)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp_p), .i_rdata(i_rdata_p),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(d_resp_p), .d_rdata(d_rdata_p),
    .mem_read(mem_read_p), .mem_write(mem_write_p), .mem_wmask(mem_wmask_p),
    .mem_address(mem_address_p), .mem_wdata(mem_wdata_p),
    .mem_resp(mem_resp_p), .mem_rdata(32'h0)
  );

  // Memory answers combinationally once wait_cfg wait cycles have elapsed.
  assign mem_resp  = force_resp | (~hold_off & (mem_read | mem_write) & (wcnt == wait_cfg));
  assign mem_rdata = tb_mem[mem_address[9:2]];
  assign mem_resp_p = mem_read_p | mem_write_p;

  always @(posedge clk) begin
    if (mem_resp && mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) tb_mem[mem_address[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if ((mem_read | mem_write) && !mem_resp) wcnt <= wcnt + 8'd1;
    else                                     wcnt <= '0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int dcnt, nresp, overlap;
  bit i_seen;

  initial begin
    for (int k = 0; k < 256; k++) tb_mem[k] = '0;
    tb_mem[8'h18] = 32'h0000_0013;   // 0x60
    tb_mem[0] = 32'h1111_0001;
    tb_mem[1] = 32'h2222_0002;
    tb_mem[2] = 32'h3333_0003;

    // Reset state
    do_reset();
    check("rst_i_resp", {31'b0, i_resp}, 32'h0);
    check("rst_d_resp", {31'b0, d_resp}, 32'h0);
    check("rst_mem_rd_wr", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", i_rdata, 32'h0);

    // Single I read, zero wait
    wait_cfg = 8'd0;
    i_read = 1'b1; i_address = 32'h60;
    step();
    check("i1_mem_read", {31'b0, mem_read}, 32'h1);
    check("i1_mem_addr", mem_address, 32'h60);
    check("i1_d_resp_n1", {31'b0, d_resp}, 32'h0);
    step();
    check("i1_i_resp", {31'b0, i_resp}, 32'h1);
    check("i1_i_rdata", i_rdata, 32'h0000_0013);
    check("i1_mem_read_done", {31'b0, mem_read}, 32'h0);
    check("i1_d_resp_n2", {31'b0, d_resp}, 32'h0);
    i_read = 1'b0;
    step();
    check("i1_i_resp_drop", {31'b0, i_resp}, 32'h0);

    // D write with 2 wait cycles
    wait_cfg = 8'd2;
    d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'h3;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("dw_mem_write_c%0d", c), {31'b0, mem_write}, 32'h1);
      check($sformatf("dw_wmask_c%0d", c), {28'b0, mem_wmask}, 32'h3);
      check($sformatf("dw_d_resp_c%0d", c), {31'b0, d_resp}, 32'h0);
    end
    step();
    check("dw_d_resp", {31'b0, d_resp}, 32'h1);
    check("dw_mem_write_done", {31'b0, mem_write}, 32'h0);
    d_write = 1'b0;
    step();

    // D read back with zero wait
    wait_cfg = 8'd0;
    d_read = 1'b1; d_address = 32'h100;
    step();
    step();
    check("dr_d_resp", {31'b0, d_resp}, 32'h1);
    check("dr_d_rdata", d_rdata, 32'h0000_BEEF);
    d_read = 1'b0;
    step();

    // Round-robin: first conflict after reset goes to D
    do_reset();
    i_read = 1'b1; i_address = 32'h0;
    d_read = 1'b1; d_address = 32'h100;
    step();
    check("rr1_first_addr", mem_address, 32'h100);
    step();
    check("rr1_d_resp", {31'b0, d_resp}, 32'h1);
    check("rr1_i_resp_n", {31'b0, i_resp}, 32'h0);
    d_read = 1'b0;
    step();
    step();
    check("rr1_second_addr", mem_address, 32'h0);
    step();
    check("rr1_i_resp", {31'b0, i_resp}, 32'h1);
    check("rr1_i_rdata", i_rdata, 32'h1111_0001);
    i_read = 1'b0;
    step();
    // D-only transfer so D is the last side served
    d_read = 1'b1; d_address = 32'h100;
    step();
    step();
    check("rr_donly_d_resp", {31'b0, d_resp}, 32'h1);
    d_read = 1'b0;
    step();
    i_read = 1'b1; i_address = 32'h60;
    d_read = 1'b1; d_address = 32'h100;
    step();
    check("rr2_first_addr", mem_address, 32'h60);
    step();
    check("rr2_i_resp", {31'b0, i_resp}, 32'h1);
    check("rr2_i_rdata", i_rdata, 32'h0000_0013);
    i_read = 1'b0;
    step();
    step();
    check("rr2_second_addr", mem_address, 32'h100);
    step();
    check("rr2_d_resp", {31'b0, d_resp}, 32'h1);
    d_read = 1'b0;
    step();

    // Fixed priority: D keeps winning while it requests
    do_reset();
    i_read = 1'b1; i_address = 32'h4;
    d_read = 1'b1; d_address = 32'h8;
    dcnt = 0; i_seen = 1'b0;
    for (int c = 0; c < 60 && !i_seen; c++) begin
      step();
      if (d_resp_p) begin
        dcnt++;
        if (dcnt == 4) d_read = 1'b0;
      end
      if (i_resp_p) begin
        i_seen = 1'b1;
        check("fp_d_count_at_i", dcnt, 4);
        i_read = 1'b0;
      end
    end
    check("fp_i_served", {31'b0, i_seen}, 32'h1);
    step();

    // Reset in BUSY_D with the memory response withheld
    do_reset();
    hold_off = 1'b1;
    d_read = 1'b1; d_address = 32'h100; d_wmask = 4'hF; d_wdata = 32'h1234_5678;
    step();
    step();
    check("rb_busy_mem_read", {31'b0, mem_read}, 32'h1);
    rst_n = 1'b0;
    step();
    check("rb_mem_rd_wr", {30'b0, mem_read, mem_write}, 32'h0);
    check("rb_mem_addr", mem_address, 32'h0);
    check("rb_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    check("rb_mem_wdata", mem_wdata, 32'h0);
    check("rb_resps", {30'b0, i_resp, d_resp}, 32'h0);
    rst_n = 1'b1; d_read = 1'b0; hold_off = 1'b0;
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    check("rb_late_resp_c0", {30'b0, i_resp, d_resp}, 32'h0);
    step();
    check("rb_late_resp_c1", {30'b0, i_resp, d_resp}, 32'h0);

    // Back-to-back I reads
    do_reset();
    wait_cfg = 8'd0;
    i_read = 1'b1; i_address = 32'h0;
    nresp = 0; overlap = 0;
    for (int k = 0; k < 20 && nresp < 3; k++) begin
      step();
      if (i_resp && mem_read) overlap++;
      if (i_resp) begin
        check($sformatf("b2b_cycle_%0d", nresp), k + 1, 2 + 3 * nresp);
        check($sformatf("b2b_rdata_%0d", nresp), i_rdata, 32'h1111_0001 * (nresp + 1));
        nresp++;
        i_address = i_address + 32'd4;
        if (nresp == 3) i_read = 1'b0;
      end
    end
    check("b2b_count", nresp, 3);
    check("b2b_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
